// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode skid-buffer stage.
// Holds the occupancy state encoding and the MIPS no-op word.
package pipe_pkg;

   // EMPTY: nothing held; FULL: main register only; SKID: main and skid registers.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } skidState_t;

   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_data_reg.sv
// Width-parametrised register with load enable and synchronous reset-to-value.
// The top instantiates it for the main {instr,pc} word and for the skid {instr,pc} word.
module pipe_data_reg #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage between fetch and decode.
// Flush empties both entries; stall_cnt counts downstream back-pressure cycles.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                PC_W     = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP),
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [PC_W-1:0]   out_pc,
   output logic [CNT_W-1:0]  stall_cnt,
   output skidState_t        dbgState
);

   localparam int               REG_W   = DATA_W + PC_W;
   localparam logic [REG_W-1:0] REG_RST = {NOP_WORD, {PC_W{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   skidState_t       state;
   skidState_t       stateNext;
   logic             inTx;
   logic             outTx;
   logic             mainEn;
   logic             skidEn;
   logic             clearRegs;
   logic [REG_W-1:0] inWord;
   logic [REG_W-1:0] mainD;
   logic [REG_W-1:0] mainQ;
   logic [REG_W-1:0] skidQ;

   // Handshake: a word moves across a port on a rising edge where valid and ready are
   // both high; valid never depends on ready, and in_ready depends on state alone.
   assign inTx      = in_valid & in_ready;
   assign outTx     = out_valid & out_ready;
   assign inWord    = {in_instr, in_pc};
   assign clearRegs = reset | flush;

   always_comb begin
      stateNext = state;
      mainEn    = 1'b0;
      skidEn    = 1'b0;
      mainD     = inWord;
      unique case (state)
         EMPTY: begin
            if (inTx) begin
               stateNext = FULL;
               mainEn    = 1'b1;
            end
         end
         FULL: begin
            if (inTx && outTx) begin
               mainEn = 1'b1;
            end else if (inTx) begin
               stateNext = SKID;
               skidEn    = 1'b1;
            end else if (outTx) begin
               stateNext = EMPTY;
            end
         end
         SKID: begin
            if (outTx) begin
               stateNext = FULL;
               mainEn    = 1'b1;
               mainD     = skidQ;
            end
         end
         default: stateNext = EMPTY;
      endcase
      if (flush) begin
         stateNext = EMPTY;
      end
   end

   // Handshake flags are registered from the next state so they never see out_ready combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= stateNext;
         out_valid <= (stateNext != EMPTY);
         in_ready  <= (stateNext != SKID);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   pipe_data_reg #(.W(REG_W), .RST_VAL(REG_RST)) mainReg (
      .clk (clk),
      .rst (clearRegs),
      .en  (mainEn),
      .d   (mainD),
      .q   (mainQ)
   );

   pipe_data_reg #(.W(REG_W), .RST_VAL(REG_RST)) skidReg (
      .clk (clk),
      .rst (clearRegs),
      .en  (skidEn),
      .d   (inWord),
      .q   (skidQ)
   );

   assign out_instr = out_valid ? mainQ[REG_W-1:PC_W] : NOP_WORD;
   assign out_pc    = out_valid ? mainQ[PC_W-1:0]     : '0;
   assign dbgState  = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage: reset, single word, streaming,
// skid fill/drain, flush, stall counter saturation and reset while holding two words.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 2;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;
  logic [CNT_W-1:0]  stall_cnt;
  skidState_t        dbg_state;

  int vectors = 0;
  int errors  = 0;
  logic [DATA_W-1:0] exp_q[$];

  pipe_skid_stage #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .NOP_WORD (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .stall_cnt (stall_cnt),
    .dbgState  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] instr, input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    reset    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    idle_inputs();
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b i=%h pc=%h cnt=%0d, want v=0 i=%h pc=0 cnt=0",
               out_valid, out_instr, out_pc, stall_cnt, NOP);
    end
    vectors++;
    if (in_ready !== 1'b1 || dbg_state !== EMPTY) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b state=%0d, want 1/EMPTY", in_ready, dbg_state);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    push(32'h2008_0005, 32'h0000_0004);
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h2008_0005 || out_pc !== 32'h0000_0004) begin
      errors++;
      $display("FAIL single_word: got v=%b i=%h pc=%h, want v=1 i=20080005 pc=00000004",
               out_valid, out_instr, out_pc);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== '0) begin
      errors++;
      $display("FAIL single_drain: got v=%b i=%h pc=%h, want v=0 i=%h pc=0",
               out_valid, out_instr, out_pc, NOP);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp;
    do_reset();
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: got in_ready=%b, want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_instr = 32'h100 + i;
      in_pc    = 32'(4 * i);
      exp_q.push_back(32'h100 + i);
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || out_instr !== exp || out_pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_word[%0d]: got v=%b i=%h pc=%h, want v=1 i=%h pc=%h",
                 i, out_valid, out_instr, out_pc, exp, 32'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_end: got v=%b pending=%0d, want v=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_skid();
    do_reset();
    out_ready = 1'b0;
    push(32'h0000_000A, 32'h10);
    push(32'h0000_000B, 32'h14);
    vectors++;
    if (dbg_state !== SKID || in_ready !== 1'b0 || out_instr !== 32'h0000_000A) begin
      errors++;
      $display("FAIL skid_fill: got state=%0d in_ready=%b i=%h, want SKID/0/0000000a",
               dbg_state, in_ready, out_instr);
    end
    // a word offered while SKID must be ignored
    push(32'h0000_000D, 32'h18);
    vectors++;
    if (dbg_state !== SKID || out_instr !== 32'h0000_000A || out_pc !== 32'h10) begin
      errors++;
      $display("FAIL skid_hold: got state=%0d i=%h pc=%h, want SKID i=0000000a pc=00000010",
               dbg_state, out_instr, out_pc);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0000_000B || out_pc !== 32'h14 || dbg_state !== FULL) begin
      errors++;
      $display("FAIL skid_drain1: got v=%b i=%h pc=%h state=%0d, want v=1 i=0000000b pc=00000014 FULL",
               out_valid, out_instr, out_pc, dbg_state);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain2: got v=%b i=%h in_ready=%b, want v=0 i=%h in_ready=1",
               out_valid, out_instr, in_ready, NOP);
    end
  endtask

  task automatic test_flush();
    do_reset();
    push(32'h0000_000A, 32'h10);
    push(32'h0000_000B, 32'h14);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000_000C;
    in_pc    = 32'h18;
    tick();
    idle_inputs();
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_skid: got v=%b i=%h pc=%h in_ready=%b, want v=0 i=%h pc=0 in_ready=1",
               out_valid, out_instr, out_pc, in_ready, NOP);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_leak[%0d]: got v=%b i=%h, want v=0", i, out_valid, out_instr);
      end
    end
    // flush coinciding with a consumer transfer: the word is taken, nothing follows
    out_ready = 1'b0;
    push(32'h0000_00E1, 32'h20);
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0000_00E1) begin
      errors++;
      $display("FAIL flush_take_pre: got v=%b i=%h, want v=1 i=000000e1", out_valid, out_instr);
    end
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP) begin
      errors++;
      $display("FAIL flush_take_post: got v=%b i=%h, want v=0 i=%h", out_valid, out_instr, NOP);
    end
  endtask

  task automatic test_stall_cnt();
    logic [CNT_W-1:0] exp_cnt[5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    push(32'h0000_0033, 32'h30);
    vectors++;
    if (stall_cnt !== 2'd0) begin
      errors++;
      $display("FAIL stall_start: got %0d, want 0", stall_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (stall_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL stall_cnt[%0d]: got %0d, want %0d", i, stall_cnt, exp_cnt[i]);
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (stall_cnt !== 2'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: got cnt=%0d v=%b, want cnt=3 v=0", stall_cnt, out_valid);
    end
    tick();
    vectors++;
    if (stall_cnt !== 2'd3) begin
      errors++;
      $display("FAIL stall_idle: got %0d, want 3", stall_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (stall_cnt !== 2'd0) begin
      errors++;
      $display("FAIL stall_reset: got %0d, want 0", stall_cnt);
    end
  endtask

  task automatic test_reset_in_skid();
    do_reset();
    push(32'h0000_000A, 32'h10);
    push(32'h0000_000B, 32'h14);
    tick();
    reset    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000_000C;
    tick();
    reset = 1'b0;
    idle_inputs();
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== '0 || stall_cnt !== '0 ||
        in_ready !== 1'b1 || dbg_state !== EMPTY) begin
      errors++;
      $display("FAIL reset_skid: got v=%b i=%h pc=%h cnt=%0d rdy=%b st=%0d, want 0/%h/0/0/1/EMPTY",
               out_valid, out_instr, out_pc, stall_cnt, in_ready, dbg_state, NOP);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_skid_discard: got v=%b i=%h, want v=0", out_valid, out_instr);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_flush();
    test_stall_cnt();
    test_reset_in_skid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
